// File: rtl/shift_seq_unit.sv
`default_nettype none
// ============================================================================
// Module      : shift_seq_unit
// Description : Multi-cycle WIDTH-bit shift/rotate unit. The operand moves one
//               bit position per clock for a run-time number of steps.
//               Operations are LSL, LSR, ASR, ROL and ROR. A start/ready/done
//               handshake controls the unit. The last bit shifted out is
//               reported on carry_out.
// Ports       : clk        - rising-edge clock
//               rst        - synchronous active-high reset
//               start      - request, sampled only while ready=1
//               data_in    - operand, captured on the start edge
//               amount     - number of single-bit steps, captured on start
//               mode       - 000 LSL, 001 LSR, 010 ASR, 011 ROL, 100 ROR,
//                            101-111 reserved
//               shift_in   - fill bit for LSL (into LSB) and LSR (into MSB)
//               ready      - high in IDLE
//               busy       - high in SHIFT
//               done       - one-cycle completion pulse
//               result     - shifted operand, held until the next start
//               carry_out  - last bit shifted/rotated out, 0 if no step taken
//               mode_err   - high with done when the accepted mode was reserved
// Revision    : 1.0 - initial release
// ============================================================================
module shift_seq_unit #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AMT_W-1:0] amount,
    input  logic [2:0]       mode,
    input  logic             shift_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             mode_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [2:0] M_LSL = 3'd0;
    localparam logic [2:0] M_LSR = 3'd1;
    localparam logic [2:0] M_ASR = 3'd2;
    localparam logic [2:0] M_ROL = 3'd3;
    localparam logic [2:0] M_ROR = 3'd4;

    localparam logic [AMT_W-1:0] c_one = AMT_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [WIDTH-1:0] r_result;
    logic [AMT_W-1:0] r_count;
    logic [2:0]       r_mode;
    logic             r_fill;
    logic             r_carry;
    logic             r_mode_err;
    logic [WIDTH-1:0] w_step_result;
    logic             w_step_out;
    logic             w_mode_rsvd;
    logic             w_no_steps;

    // Modes above ROR are reserved; such requests complete without shifting.
    assign w_mode_rsvd = (mode > M_ROR);
    assign w_no_steps  = (amount == '0) || w_mode_rsvd;

    // One single-bit step of the latched operation.
    always_comb begin
        w_step_result = r_result;
        w_step_out    = 1'b0;
        case (r_mode)
            M_LSL: begin
                w_step_result = {r_result[WIDTH-2:0], r_fill};
                w_step_out    = r_result[WIDTH-1];
            end
            M_LSR: begin
                w_step_result = {r_fill, r_result[WIDTH-1:1]};
                w_step_out    = r_result[0];
            end
            M_ASR: begin
                w_step_result = {r_result[WIDTH-1], r_result[WIDTH-1:1]};
                w_step_out    = r_result[0];
            end
            M_ROL: begin
                w_step_result = {r_result[WIDTH-2:0], r_result[WIDTH-1]};
                w_step_out    = r_result[WIDTH-1];
            end
            M_ROR: begin
                w_step_result = {r_result[0], r_result[WIDTH-1:1]};
                w_step_out    = r_result[0];
            end
            default: begin
                w_step_result = r_result;
                w_step_out    = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic. SHIFT is only entered with a non-zero count, so the
    // last step is the one taken while the count equals one.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = w_no_steps ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_count == c_one) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: operand capture and stepping. The count always runs the raw
    // amount, so amounts beyond WIDTH take the full number of cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result   <= '0;
            r_count    <= '0;
            r_mode     <= M_LSL;
            r_fill     <= 1'b0;
            r_carry    <= 1'b0;
            r_mode_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_result   <= data_in;
                        r_count    <= amount;
                        r_mode     <= mode;
                        r_fill     <= shift_in;
                        r_carry    <= 1'b0;
                        r_mode_err <= w_mode_rsvd;
                    end
                end
                S_SHIFT: begin
                    r_result <= w_step_result;
                    r_carry  <= w_step_out;
                    r_count  <= r_count - c_one;
                end
                default: begin
                    r_result <= r_result;
                end
            endcase
        end
    end

    assign ready     = (r_state == S_IDLE);
    assign busy      = (r_state == S_SHIFT);
    assign done      = (r_state == S_DONE);
    assign result    = r_result;
    assign carry_out = r_carry;
    assign mode_err  = (r_state == S_DONE) && r_mode_err;

endmodule
`default_nettype wire

// File: doc/shift_seq_unit.md
Name: shift_seq_unit

Overview:
- Parametrised, multi-cycle successor to the gate-level 4/8-bit shifters.
- Shifts or rotates a WIDTH-bit operand by a run-time amount, one bit position per clock. Supports five modes.
- Uses a start/ready/done handshake.
- Reports the last bit shifted out, the successor of the bb_left/bb_right boundary bits.
- Serves as the shift execution unit of the ALU datapath.

Parameters:
- WIDTH, default 8: operand/result width in bits; legal range is 4 or more.
- AMT_W, default $clog2(WIDTH)+1: width of the shift-amount port. Allows amounts up to 2^AMT_W-1, which can exceed WIDTH.

Ports:
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when ready=1
- data_in  input  WIDTH  operand, captured on the start edge
- amount  input  AMT_W  number of single-bit steps, captured on the start edge
- mode  input  3  operation select, captured on the start edge: 000 LSL, 001 LSR, 010 ASR, 011 ROL, 100 ROR, 101-111 reserved
- shift_in  input  1  fill bit, captured on the start edge. Enters the LSB for LSL and the MSB for LSR. Ignored for ASR/ROL/ROR.
- ready  output  1  high only in IDLE
- busy  output  1  high in SHIFT
- done  output  1  one-cycle completion pulse
- result  output  WIDTH  shifted operand; holds its value until the next start is accepted
- carry_out  output  1  last bit shifted/rotated out; 0 if no step was taken
- mode_err  output  1  high with done when the accepted mode was reserved

Behaviour:
- Reset (the edge on which rst=1): state=IDLE, result=0, carry_out=0, done=0, busy=0, mode_err=0, ready=1.
- Reset has priority over everything. It aborts SHIFT or DONE immediately with no done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE, edge with start=1:
  - Load result<=data_in, count<=amount, and latch mode and shift_in.
  - Clear carry_out.
  - If amount=0 or mode is reserved, go to DONE; otherwise go to SHIFT.
- SHIFT, each edge: perform one step on result, set carry_out to the bit leaving the register, and decrement count. When count reaches 0, go to DONE.
- Step definitions:
  - LSL: result <= {result[W-2:0], shift_in}; out = result[W-1].
  - LSR: result <= {shift_in, result[W-1:1]}; out = result[0].
  - ASR: result <= {result[W-1], result[W-1:1]}; out = result[0].
  - ROL: result <= {result[W-2:0], result[W-1]}; out = result[W-1].
  - ROR: result <= {result[0], result[W-1:1]}; out = result[0].
- DONE: done=1 for exactly one cycle, then IDLE on the next edge.
- Reserved mode: result = data_in unchanged, carry_out=0, mode_err=1 during the done cycle.
- Latency: for amount=k, done is high during the cycle after the k-th edge following the start edge. For k=0, done is high in the cycle right after the start edge. Minimum start-to-start spacing is k+2 cycles.
- Amount >= WIDTH:
  - Logical shifts fully saturate to the fill pattern.
  - ASR saturates to sign replication.
  - Rotates are effectively modulo WIDTH.
  - The cycle count is always the raw amount; no modulo shortcut is taken.
- start while ready=0 is ignored and not queued. data_in, amount, mode and shift_in changing during SHIFT have no effect.
- result and carry_out are stable from the done cycle until the next accepted start; they are undefined only while busy=1.

Test Plan:
1. Assert rst for 2 cycles mid-SHIFT (WIDTH=8, ROL 0xA5, amount 5, rst after 2 steps) -> next cycle result=0x00, carry_out=0, ready=1, busy=0, no done pulse.
2. LSL data_in=0x96, amount=3, shift_in=0 -> busy for 3 cycles, then done one cycle with result=0xB0, carry_out=0; ready returns the following cycle.
3. ASR data_in=0x96, amount=2 -> result=0xE5, carry_out=1, done in the cycle after the 2nd edge.
4. ROR data_in=0x96, amount=10 -> 10 busy cycles, result=0xA5, carry_out=1. Also ROL 0x81 amount=8 -> result=0x81, carry_out=1.
5. LSR data_in=0x96, amount=9, shift_in=1 -> result=0xFF, carry_out=1. Also amount=0 with any mode -> done the cycle after start, result=data_in, carry_out=0.
6. Hold start=1 continuously with changing data_in during SHIFT -> only the first operand is processed; a new start is accepted only once ready=1. Mode=110 -> done next cycle with result=data_in and mode_err=1.
